// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port fixed-priority arbiter with port-1 anti-starvation in front of single-port data memory.
// Optional DMEM_ARB_ALIGN_CHECK_EN blocks misaligned accesses and reports them on err0/err1.
package dmem_pkg;
  typedef enum logic [3:0] {
    MEM_NOP, MEM_SB, MEM_SH, MEM_SW, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU
  } mem_op_t;
endpackage

module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  mem_op_t     op0,
  input  mem_op_t     op1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic        mem_wr_en,
  output mem_op_t     mem_ctrl,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);
  localparam logic [CNT_W-1:0] MW = CNT_W'(MAX_WAIT);
  logic [CNT_W-1:0] cnt;
  logic force_q, we, bad;
  mem_op_t op;
  logic [31:0] addr, rd;
  assign gnt1 = req1 & (force_q | ~req0);
  assign gnt0 = req0 & ~gnt1;
  always_comb begin
    op   = gnt1 ? op1 : gnt0 ? op0 : MEM_NOP;
    we   = gnt1 ? we1 : gnt0 & we0;
    addr = gnt1 ? addr1 : gnt0 ? addr0 : '0;
    mem_data_in = gnt1 ? wdata1 : gnt0 ? wdata0 : '0;
  end
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign bad = ((op == MEM_SH || op == MEM_LH || op == MEM_LHU) & addr[0]) |
               ((op == MEM_SW || op == MEM_LW) & (|addr[1:0]));
`else
  assign bad = 1'b0;
`endif
  assign mem_wr_en = we & ~bad;
  assign mem_ctrl  = bad ? MEM_NOP : op;
  assign mem_addr  = addr;
  // stores and blocked accesses answer with zero data
  assign rd = (we | bad) ? '0 : mem_data_out;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      cnt     <= '0;
      force_q <= 1'b0;
    end else begin
      rvalid0 <= gnt0;
      rvalid1 <= gnt1;
      if (gnt0) {rdata0, err0} <= {rd, bad};
      if (gnt1) {rdata1, err1} <= {rd, bad};
      cnt     <= (gnt1 | ~req1) ? '0 : (cnt == MW) ? cnt : cnt + 1'b1;
      force_q <= req1 & ~gnt1 & (cnt == MW);
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven and directed checks of dmem_arbiter against a byte-addressed memory model.
module tb_dmem_arbiter;
  import dmem_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  mem_op_t op0 = MEM_NOP, op1 = MEM_NOP;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_wr_en;
  logic [31:0] rdata0, rdata1, mem_addr, mem_data_in, mem_data_out;
  mem_op_t mem_ctrl;
  int checks = 0, errors = 0;

  dmem_arbiter u_dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .op0(op0), .op1(op1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_wr_en(mem_wr_en), .mem_ctrl(mem_ctrl), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:1023] = '{default: 8'h00};
  logic [9:0] ma;
  assign ma = mem_addr[9:0];
  always_comb begin
    mem_data_out = '0;
    case (mem_ctrl)
      MEM_LB:  mem_data_out = {{24{mem[ma][7]}}, mem[ma]};
      MEM_LBU: mem_data_out = {24'h0, mem[ma]};
      MEM_LH:  mem_data_out = {{16{mem[ma+10'd1][7]}}, mem[ma+10'd1], mem[ma]};
      MEM_LHU: mem_data_out = {16'h0, mem[ma+10'd1], mem[ma]};
      MEM_LW:  mem_data_out = {mem[ma+10'd3], mem[ma+10'd2], mem[ma+10'd1], mem[ma]};
      default: mem_data_out = '0;
    endcase
  end
  always @(posedge clk) begin
    if (mem_wr_en) begin
      if (mem_ctrl == MEM_SB || mem_ctrl == MEM_SH || mem_ctrl == MEM_SW) mem[ma] <= mem_data_in[7:0];
      if (mem_ctrl == MEM_SH || mem_ctrl == MEM_SW) mem[ma+10'd1] <= mem_data_in[15:8];
      if (mem_ctrl == MEM_SW) begin
        mem[ma+10'd2] <= mem_data_in[23:16];
        mem[ma+10'd3] <= mem_data_in[31:24];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic r0, w0; mem_op_t o0; logic [31:0] a0, d0;
    logic r1, w1; mem_op_t o1; logic [31:0] a1, d1;
    logic g0, g1, v0, v1, mwe;
    logic [31:0] q0, q1;
  } vec_t;
  vec_t tv [10];

  initial begin
    logic [31:0] exp_word;
    tv[0] = '{1'b1,1'b1,MEM_SW,32'd100,32'h89ABCDEF, 1'b0,1'b0,MEM_NOP,32'd0,32'd0, 1'b1,1'b0,1'b0,1'b0,1'b1, 32'h0,32'h0};
    tv[1] = '{1'b1,1'b0,MEM_LW,32'd100,32'd0, 1'b0,1'b0,MEM_NOP,32'd0,32'd0, 1'b1,1'b0,1'b1,1'b0,1'b0, 32'h0,32'h0};
    tv[2] = '{1'b0,1'b0,MEM_NOP,32'd0,32'd0, 1'b1,1'b0,MEM_LBU,32'd100,32'd0, 1'b0,1'b1,1'b1,1'b0,1'b0, 32'h89ABCDEF,32'h0};
    tv[3] = '{1'b0,1'b0,MEM_NOP,32'd0,32'd0, 1'b1,1'b0,MEM_LH,32'd102,32'd0, 1'b0,1'b1,1'b0,1'b1,1'b0, 32'h89ABCDEF,32'h000000EF};
    tv[4] = '{1'b0,1'b0,MEM_NOP,32'd0,32'd0, 1'b0,1'b0,MEM_NOP,32'd0,32'd0, 1'b0,1'b0,1'b0,1'b1,1'b0, 32'h89ABCDEF,32'hFFFF89AB};
    tv[5] = '{1'b1,1'b1,MEM_SB,32'd104,32'h000000A5, 1'b0,1'b0,MEM_NOP,32'd0,32'd0, 1'b1,1'b0,1'b0,1'b0,1'b1, 32'h89ABCDEF,32'hFFFF89AB};
    tv[6] = '{1'b1,1'b0,MEM_LB,32'd104,32'd0, 1'b0,1'b0,MEM_NOP,32'd0,32'd0, 1'b1,1'b0,1'b1,1'b0,1'b0, 32'h0,32'hFFFF89AB};
    tv[7] = '{1'b1,1'b1,MEM_SH,32'd106,32'h12348001, 1'b0,1'b0,MEM_NOP,32'd0,32'd0, 1'b1,1'b0,1'b1,1'b0,1'b1, 32'hFFFFFFA5,32'hFFFF89AB};
    tv[8] = '{1'b0,1'b0,MEM_NOP,32'd0,32'd0, 1'b1,1'b0,MEM_LHU,32'd106,32'd0, 1'b0,1'b1,1'b1,1'b0,1'b0, 32'h0,32'hFFFF89AB};
    tv[9] = '{1'b0,1'b0,MEM_NOP,32'd0,32'd0, 1'b0,1'b0,MEM_NOP,32'd0,32'd0, 1'b0,1'b0,1'b0,1'b1,1'b0, 32'h0,32'h00008001};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", {gnt0, gnt1}, 0);
    chk("rst_rvalid", {rvalid0, rvalid1, err0, err1}, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("idle_mem", {mem_wr_en, 28'(mem_ctrl)}, {1'b0, 28'(MEM_NOP)});
    chk("idle_addr_data", mem_addr | mem_data_in, 0);
    rst = 1'b0;

    foreach (tv[i]) begin
      @(negedge clk);
      {req0, we0, op0, addr0, wdata0} = {tv[i].r0, tv[i].w0, tv[i].o0, tv[i].a0, tv[i].d0};
      {req1, we1, op1, addr1, wdata1} = {tv[i].r1, tv[i].w1, tv[i].o1, tv[i].a1, tv[i].d1};
      #1;
      chk($sformatf("v%0d_gnt", i), {gnt0, gnt1}, {tv[i].g0, tv[i].g1});
      chk($sformatf("v%0d_rvalid", i), {rvalid0, rvalid1}, {tv[i].v0, tv[i].v1});
      chk($sformatf("v%0d_wr_en", i), mem_wr_en, tv[i].mwe);
      chk($sformatf("v%0d_rdata0", i), rdata0, tv[i].q0);
      chk($sformatf("v%0d_rdata1", i), rdata1, tv[i].q1);
    end

    // port 1 starved by continuous port-0 traffic
    @(negedge clk);
    {req0, we0, op0, addr0} = {1'b1, 1'b0, MEM_LW, 32'd100};
    {req1, we1, op1, addr1} = {1'b1, 1'b0, MEM_LW, 32'd104};
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("starve_c%0d_gnt", c), {gnt0, gnt1}, (c < 5) ? 2'b10 : 2'b01);
      if (c > 0) chk($sformatf("starve_c%0d_rvalid0", c), {rvalid0, rdata0}, {1'b1, 32'h89ABCDEF});
      @(negedge clk);
    end
    req1 = 1'b0;
    #1;
    chk("starve_resume_gnt", {gnt0, gnt1}, 2'b10);
    chk("starve_cnt", 32'(u_dut.cnt), 0);
    chk("starve_rdata1", {rvalid1, rdata1}, {1'b1, 32'h800100A5});

    // simultaneous stores to one address
    @(negedge clk);
    {req0, we0, op0, addr0, wdata0} = {1'b1, 1'b1, MEM_SW, 32'd200, 32'h11111111};
    {req1, we1, op1, addr1, wdata1} = {1'b1, 1'b1, MEM_SW, 32'd200, 32'h22222222};
    #1 chk("sim_c0_gnt", {gnt0, gnt1}, 2'b10);
    @(negedge clk);
    req0 = 1'b0;
    #1 chk("sim_c1_gnt", {gnt0, gnt1}, 2'b01);
    chk("sim_c1_ack0", {rvalid0, rdata0}, {1'b1, 32'h0});
    @(negedge clk);
    req1 = 1'b0;
    {req0, we0, op0, addr0} = {1'b1, 1'b0, MEM_LW, 32'd200};
    #1 chk("sim_c2_gnt", {gnt0, gnt1}, 2'b10);
    chk("sim_c2_ack1", {rvalid1, rdata1}, {1'b1, 32'h0});
    @(negedge clk);
    req0 = 1'b0;
    #1 chk("sim_lw200", {rvalid0, rdata0}, {1'b1, 32'h22222222});

    // reset while a load response is pending
    @(negedge clk);
    {req0, we0, op0, addr0} = {1'b1, 1'b0, MEM_LW, 32'd100};
    {req1, we1, op1, addr1} = {1'b1, 1'b0, MEM_LW, 32'd100};
    #1 chk("rst_mid_gnt", {gnt0, gnt1}, 2'b10);
    @(negedge clk);
    #1 chk("rst_mid_pre", {rvalid0, rdata0}, {1'b1, 32'h89ABCDEF});
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    #1;
    chk("rst_mid_rvalid0", {rvalid0, rdata0}, 0);
    chk("rst_mid_cnt", 32'(u_dut.cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    req1 = 1'b1;
    #1 chk("rst_after_gnt", {gnt0, gnt1}, 2'b01);
    @(negedge clk);
    req1 = 1'b0;
    #1 chk("rst_after_rdata1", {rvalid1, rdata1}, {1'b1, 32'h89ABCDEF});

    // misaligned store
    @(negedge clk);
    {req0, we0, op0, addr0, wdata0} = {1'b1, 1'b1, MEM_SW, 32'd102, 32'hDEADBEEF};
    #1 chk("mis_gnt", {gnt0, gnt1}, 2'b10);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    chk("mis_mem", {mem_wr_en, 28'(mem_ctrl)}, {1'b0, 28'(MEM_NOP)});
    exp_word = 32'h89ABCDEF;
`else
    chk("mis_mem", {mem_wr_en, 28'(mem_ctrl)}, {1'b1, 28'(MEM_SW)});
    exp_word = 32'hBEEFCDEF;
`endif
    @(negedge clk);
    {we0, op0, addr0} = {1'b0, MEM_LW, 32'd100};
    #1;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    chk("mis_resp", {rvalid0, err0, rdata0}, {2'b11, 32'h0});
`else
    chk("mis_resp", {rvalid0, err0, rdata0}, {2'b10, 32'h0});
`endif
    @(negedge clk);
    req0 = 1'b0;
    #1 chk("mis_lw100", {rvalid0, err0, rdata0}, {2'b10, exp_word});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
